// File: rtl/switch_debounce_events.sv
// 64-bit switch debouncer with per-bit edge events.
// Events leave lowest-index first on a valid/ready stream.
module switch_debounce_events #(
    parameter int TICK_DIV = 1000,
    parameter int STABLE_N = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_0,
    input  logic [15:0] data_1,
    input  logic [15:0] data_2,
    input  logic [15:0] data_3,
    output logic [15:0] stable_0,
    output logic [15:0] stable_1,
    output logic [15:0] stable_2,
    output logic [15:0] stable_3,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [5:0]  evt_index,
    output logic        evt_rise,
    output logic        pending_any,
    output logic        evt_dropped,
    input  logic        clr_dropped
);

    localparam logic [15:0] TICK_MAX  = 16'(TICK_DIV - 1);
    localparam logic [3:0]  AGREE_MAX = 4'(STABLE_N - 1);

    logic [15:0] tick_cnt;
    logic        tick;
    logic [63:0] raw;
    logic [63:0] stable;
    logic [3:0]  agree [64];
    logic [63:0] edge_v;
    logic [63:0] pend;
    logic [63:0] pol;
    logic [63:0] pend_nxt;
    logic [63:0] pol_nxt;
    logic [63:0] cons;
    logic [5:0]  sel;
    logic        any_pend;
    logic        out_free;
    logic        load;
    logic        drop;

    assign raw  = {data_3, data_2, data_1, data_0};
    assign tick = (tick_cnt == TICK_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    always_comb begin
        edge_v = '0;
        for (int i = 0; i < 64; i++) begin
            edge_v[i] = tick && (raw[i] != stable[i])
                        && (agree[i] == AGREE_MAX);
        end
    end

    // Any agreeing sample restarts the count of differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < 64; i++) begin
                agree[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < 64; i++) begin
                if (raw[i] == stable[i]) begin
                    agree[i] <= '0;
                end else if (agree[i] == AGREE_MAX) begin
                    stable[i] <= raw[i];
                    agree[i]  <= '0;
                end else begin
                    agree[i] <= agree[i] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        sel = '0;
        for (int i = 63; i >= 0; i--) begin
            if (pend[i]) begin
                sel = 6'(i);
            end
        end
    end

    assign any_pend = |pend;
    assign out_free = !evt_valid || evt_ready;
    assign load     = out_free && any_pend;
    assign cons     = load ? (64'd1 << sel) : 64'd0;

    // A new edge on a bit whose opposite edge is still unreported
    // cancels the pair; a bit being consumed this cycle re-arms instead.
    always_comb begin
        pend_nxt = pend & ~cons;
        pol_nxt  = pol;
        drop     = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (edge_v[i]) begin
                if (pend[i] && !cons[i]) begin
                    pend_nxt[i] = 1'b0;
                    drop        = 1'b1;
                end else begin
                    pend_nxt[i] = 1'b1;
                    pol_nxt[i]  = raw[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend        <= '0;
            pol         <= '0;
            evt_valid   <= 1'b0;
            evt_index   <= '0;
            evt_rise    <= 1'b0;
            evt_dropped <= 1'b0;
        end else begin
            pend <= pend_nxt;
            pol  <= pol_nxt;
            if (out_free) begin
                evt_valid <= any_pend;
                if (any_pend) begin
                    evt_index <= sel;
                    evt_rise  <= pol[sel];
                end
            end
            if (drop) begin
                evt_dropped <= 1'b1;
            end else if (clr_dropped) begin
                evt_dropped <= 1'b0;
            end
        end
    end

    assign pending_any = any_pend;
    assign stable_0    = stable[15:0];
    assign stable_1    = stable[31:16];
    assign stable_2    = stable[47:32];
    assign stable_3    = stable[63:48];

endmodule

// File: tb/tb_switch_debounce_events.sv
// Bench for switch_debounce_events: directed table plus
// randomized run against a cycle-level reference model.
module tb_switch_debounce_events;

    localparam int TD = 4;
    localparam int SN = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_0, data_1, data_2, data_3;
    logic [15:0] stable_0, stable_1, stable_2, stable_3;
    logic        evt_valid, evt_ready;
    logic [5:0]  evt_index;
    logic        evt_rise, pending_any, evt_dropped, clr_dropped;

    int n_cmp = 0;
    int n_err = 0;

    switch_debounce_events #(.TICK_DIV(TD), .STABLE_N(SN)) dut (
        .clk(clk), .reset(reset),
        .data_0(data_0), .data_1(data_1),
        .data_2(data_2), .data_3(data_3),
        .stable_0(stable_0), .stable_1(stable_1),
        .stable_2(stable_2), .stable_3(stable_3),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_index(evt_index), .evt_rise(evt_rise),
        .pending_any(pending_any), .evt_dropped(evt_dropped),
        .clr_dropped(clr_dropped)
    );

    always #5 clk = ~clk;

    // Reference model state
    int          m_phase;
    int          m_run [64];
    bit [63:0]   m_st, m_pend, m_pol;
    bit          m_valid, m_rise, m_drop;
    int          m_idx;

    function automatic logic [63:0] dut_st();
        return {stable_3, stable_2, stable_1, stable_0};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err < 30)
                $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_step(bit rst, bit [63:0] r, bit rdy, bit clr);
        bit [63:0] edges;
        bit tk;
        bit lost;
        int lo;
        if (rst) begin
            m_phase = 0;
            m_st = '0; m_pend = '0; m_pol = '0;
            m_valid = 0; m_rise = 0; m_drop = 0; m_idx = 0;
            for (int i = 0; i < 64; i++) m_run[i] = 0;
            return;
        end
        tk = (m_phase == TD - 1);
        m_phase = tk ? 0 : m_phase + 1;
        edges = '0;
        if (tk) begin
            for (int i = 0; i < 64; i++) begin
                if (r[i] != m_st[i]) begin
                    m_run[i]++;
                    if (m_run[i] == SN) begin
                        edges[i] = 1;
                        m_st[i] = r[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
        if (!m_valid || rdy) begin
            lo = -1;
            for (int i = 0; i < 64; i++)
                if (m_pend[i] && lo < 0) lo = i;
            if (lo >= 0) begin
                m_valid = 1;
                m_idx = lo;
                m_rise = m_pol[lo];
                m_pend[lo] = 0;
            end else begin
                m_valid = 0;
            end
        end
        lost = 0;
        for (int i = 0; i < 64; i++) begin
            if (edges[i]) begin
                if (m_pend[i]) begin
                    m_pend[i] = 0;
                    lost = 1;
                end else begin
                    m_pend[i] = 1;
                    m_pol[i] = r[i];
                end
            end
        end
        if (lost) m_drop = 1;
        else if (clr) m_drop = 0;
    endtask

    task automatic step(bit rst, bit [63:0] r, bit rdy, bit clr);
        reset = rst;
        {data_3, data_2, data_1, data_0} = r;
        evt_ready = rdy;
        clr_dropped = clr;
        model_step(rst, r, rdy, clr);
        @(posedge clk);
        #1;
        chk("mdl_stable", dut_st(), m_st);
        chk("mdl_valid", 64'(evt_valid), 64'(m_valid));
        chk("mdl_index", 64'(evt_index), 64'(m_idx));
        chk("mdl_rise", 64'(evt_rise), 64'(m_rise));
        chk("mdl_pend_any", 64'(pending_any), 64'(|m_pend));
        chk("mdl_dropped", 64'(evt_dropped), 64'(m_drop));
    endtask

    typedef struct {
        bit          rst;
        logic [63:0] raw;
        bit          rdy;
        bit          clr;
        int          cyc;
        logic [63:0] st;
        bit          v;
        logic [5:0]  idx;
        bit          rise;
        bit          pa;
        bit          dr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, logic [63:0] raw, bit rdy,
                                bit clr, int cyc, logic [63:0] st,
                                bit v, logic [5:0] idx, bit rise,
                                bit pa, bit dr);
        vec_t t;
        t.rst = rst; t.raw = raw; t.rdy = rdy; t.clr = clr;
        t.cyc = cyc; t.st = st; t.v = v; t.idx = idx;
        t.rise = rise; t.pa = pa; t.dr = dr;
        return t;
    endfunction

    initial begin
        logic [63:0] b5, b16, d, r;
        string nm;
        b5  = 64'h20;
        b16 = 64'h1_0000;
        d   = {1'b1, 62'd0, 1'b1};
        // quiet after reset
        tbl.push_back(mk(1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 100, 0, 0, 0, 0, 0, 0));
        // single rise on bit 5
        tbl.push_back(mk(1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, b5, 0, 0, 12, b5, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, b5, 0, 0, 1, b5, 1, 5, 1, 0, 0));
        tbl.push_back(mk(0, b5, 0, 0, 5, b5, 1, 5, 1, 0, 0));
        tbl.push_back(mk(0, b5, 1, 0, 1, b5, 0, 0, 0, 0, 0));
        // short glitch on bit 16
        tbl.push_back(mk(1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, b16, 1, 0, 8, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 8, 0, 0, 0, 0, 0, 0));
        // two simultaneous rises, lowest first
        tbl.push_back(mk(1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, d, 0, 0, 13, d, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, d, 0, 0, 3, d, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, d, 1, 0, 1, d, 1, 63, 1, 0, 0));
        tbl.push_back(mk(0, d, 1, 0, 1, d, 0, 0, 0, 0, 0));
        // cancelled pair on bit 2, then clear
        tbl.push_back(mk(1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 13, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 5, 0, 0, 12, 5, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 12, 1, 1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 1, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 1, 0, 1, 0, 0));
        // reset with event in flight
        tbl.push_back(mk(1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3, 0, 0, 13, 3, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0));

        foreach (tbl[k]) begin
            for (int c = 0; c < tbl[k].cyc; c++)
                step(tbl[k].rst, tbl[k].raw, tbl[k].rdy, tbl[k].clr);
            nm = $sformatf("vec%0d", k);
            chk({nm, "_stable"}, dut_st(), tbl[k].st);
            chk({nm, "_valid"}, 64'(evt_valid), 64'(tbl[k].v));
            if (tbl[k].v) begin
                chk({nm, "_index"}, 64'(evt_index), 64'(tbl[k].idx));
                chk({nm, "_rise"}, 64'(evt_rise), 64'(tbl[k].rise));
            end
            chk({nm, "_pend_any"}, 64'(pending_any), 64'(tbl[k].pa));
            chk({nm, "_dropped"}, 64'(evt_dropped), 64'(tbl[k].dr));
        end

        // randomized traffic, bounces concentrated on low bits
        step(1, 0, 0, 0);
        r = '0;
        for (int c = 0; c < 5000; c++) begin
            int b;
            if ($urandom_range(7) == 0) begin
                b = ($urandom_range(3) == 0) ? int'($urandom_range(63))
                                             : int'($urandom_range(7));
                r[b] = ~r[b];
            end
            step($urandom_range(999) == 0, r,
                 $urandom_range(3) != 0, $urandom_range(31) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
